// File: rtl/alu_scheduler.sv
// Purpose: round-robin front end for the shared combinational ALU; registers one op, drives it, returns the result.
// Latency: accept->rsp_valid is 2 edges for single-cycle ops, MC_LAT+1 for MUL/DIV, 1 for trapped ops.
// Backpressure: one op in flight; requesters stall until IDLE; the response is held until rsp_ready is sampled high.
module alu_scheduler #(
  parameter int WORD_SIZE = 16,
  parameter int MC_LAT    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  // requester 0
  input  logic                     req0_valid,
  input  logic [3:0]               req0_op,
  input  logic [WORD_SIZE-1:0]     req0_a,
  input  logic [WORD_SIZE-1:0]     req0_b,
  output logic                     req0_ready,
  // requester 1
  input  logic                     req1_valid,
  input  logic [3:0]               req1_op,
  input  logic [WORD_SIZE-1:0]     req1_a,
  input  logic [WORD_SIZE-1:0]     req1_b,
  output logic                     req1_ready,
  // shared ALU
  output logic                     alu_enable,
  output logic [3:0]               alu_op,
  output logic [WORD_SIZE-1:0]     alu_in1,
  output logic [WORD_SIZE-1:0]     alu_in2,
  input  logic [2*WORD_SIZE-1:0]   alu_out,
  // response
  output logic                     rsp_valid,
  output logic                     rsp_id,
  output logic [2*WORD_SIZE-1:0]   rsp_data,
  output logic                     rsp_err,
  input  logic                     rsp_ready,
  output logic                     busy
);

  // Opcode map shared with the alu block.
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_MUL   = 4'h2;
  localparam logic [3:0] ALU_SLT   = 4'h3;
  localparam logic [3:0] ALU_AND   = 4'h4;
  localparam logic [3:0] ALU_OR    = 4'h5;
  localparam logic [3:0] ALU_XOR   = 4'h6;
  localparam logic [3:0] ALU_SHIFT = 4'h7;
  localparam logic [3:0] ALU_DIV   = 4'h8;

  // Last EXEC count for multicycle ops; MC_LAT is limited to 1..15 so it fits in cnt.
  localparam logic [3:0] MC_LAST = 4'(MC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic                   last_gnt;
  logic [3:0]             cnt;

  logic                   gnt;
  logic                   gnt_any;
  logic                   accept;
  logic [3:0]             sel_op;
  logic [WORD_SIZE-1:0]   sel_a;
  logic [WORD_SIZE-1:0]   sel_b;
  logic                   sel_trap;
  logic                   exec_done;

  // Opcodes the ALU implements; anything else is answered here with an error.
  function automatic logic op_known(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLT, ALU_AND,
      ALU_OR, ALU_XOR, ALU_SHIFT, ALU_DIV: op_known = 1'b1;
      default:                              op_known = 1'b0;
    endcase
  endfunction

  // MUL and DIV are multicycle paths through the ALU.
  function automatic logic op_multicycle(input logic [3:0] op);
    op_multicycle = (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt = ~last_gnt;
    end else if (req0_valid) begin
      gnt = 1'b0;
    end else begin
      gnt = 1'b1;
    end
  end

  // Ready is only offered in IDLE, and only to the granted requester.
  assign req0_ready = (state == IDLE) && gnt_any && (gnt == 1'b0);
  assign req1_ready = (state == IDLE) && gnt_any && (gnt == 1'b1);
  assign accept     = (state == IDLE) && gnt_any;

  // Payload of the granted requester and its trap decision.
  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (gnt) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
    sel_trap = !op_known(sel_op) || ((sel_op == ALU_DIV) && (sel_b == '0));
  end

  // Single-cycle ops finish on the first EXEC edge, multicycle ops after MC_LAT edges.
  assign exec_done = !op_multicycle(alu_op) || (cnt == MC_LAST);

  // Status outputs come straight from the state register, so reset clears them asynchronously.
  assign alu_enable = (state == EXEC);
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  // Main FSM: accept and register the op, hold the ALU inputs through EXEC, then hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      cnt      <= 4'd0;
      alu_op   <= '0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_op   <= sel_op;
            alu_in1  <= sel_a;
            alu_in2  <= sel_b;
            rsp_id   <= gnt;
            last_gnt <= gnt;
            cnt      <= 4'd0;
            if (sel_trap) begin
              // Trapped ops skip EXEC so the ALU never sees them enabled.
              rsp_data <= '0;
              rsp_err  <= 1'b1;
              state    <= RESP;
            end else begin
              state    <= EXEC;
            end
          end
        end
        EXEC: begin
          if (exec_done) begin
            rsp_data <= alu_out;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else begin
            cnt      <= cnt + 4'd1;
          end
        end
        RESP: begin
          // No accept from here even when rsp_ready is high; the next op starts from IDLE.
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
